// File: rtl/iq_pkg.sv
// Shared defaults and entry layout for the instruction queue.
package iq_pkg;

  localparam int IQ_DATA_W = 32;
  localparam int IQ_DEPTH  = 8;
  localparam int IQ_PC_W   = 6;

  typedef struct packed {
    logic [IQ_PC_W-1:0]   pc;
    logic [IQ_DATA_W-1:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/iq_ptr.sv
// Modulo-DEPTH pointer with synchronous clear; clear wins over increment.
module iq_ptr #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Next pointer value; power-of-two depth makes the natural wrap the modulo.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = {PTR_W{1'b0}};
    end else if (inc) begin
      ptr_d = ptr_q + PTR_W'(1'b1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= {PTR_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO with flush on branch redirect.
// Define IQ_BYPASS_EN to forward a push straight to the pop port when the queue is empty.
module inst_queue
  import iq_pkg::*;
#(
  parameter  int DATA_W   = IQ_DATA_W,
  parameter  int DEPTH    = IQ_DEPTH,
  parameter  int PC_W     = IQ_PC_W,
  parameter  int AF_LEVEL = DEPTH - 2,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_instr,
  input  logic [PC_W-1:0]   push_pc,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_instr,
  output logic [PC_W-1:0]   pop_pc,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] head_s;
  logic [PTR_W-1:0] tail_s;
  logic             bypass_s;
  logic             push_store_s;
  logic             pop_store_s;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == {CNT_W{1'b0}});
  assign almost_full = (count_q >= CNT_W'(AF_LEVEL));
  assign push_ready  = !full;
  assign count       = count_q;

`ifdef IQ_BYPASS_EN
  assign bypass_s = empty && push_valid && pop_ready && !flush;
`else
  assign bypass_s = 1'b0;
`endif

  // A bypassed word is consumed in flight and never occupies an entry.
  assign push_store_s = push_valid && push_ready && !flush && !bypass_s;
  assign pop_store_s  = !empty && pop_ready && !flush;

  iq_ptr #(.DEPTH(DEPTH)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop_store_s),
    .ptr   (head_s)
  );

  iq_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push_store_s),
    .ptr   (tail_s)
  );

  // Occupancy update; flush overrides any concurrent push or pop.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = {CNT_W{1'b0}};
    end else begin
      case ({push_store_s, pop_store_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Entry write at the tail.
  always_comb begin
    mem_d = mem_q;
    if (push_store_s) begin
      mem_d[tail_s] = '{pc: push_pc, instr: push_instr};
    end else begin
      mem_d = mem_q;
    end
  end

  // Head presentation, zeroed whenever nothing is offered to decode.
  always_comb begin
    pop_valid = 1'b0;
    pop_instr = {DATA_W{1'b0}};
    pop_pc    = {PC_W{1'b0}};
    if (bypass_s) begin
      pop_valid = 1'b1;
      pop_instr = push_instr;
      pop_pc    = push_pc;
    end else if (!empty) begin
      pop_valid = 1'b1;
      pop_instr = mem_q[head_s].instr;
      pop_pc    = mem_q[head_s].pc;
    end else begin
      pop_valid = 1'b0;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {$bits(entry_t){1'b0}};
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule
